// File: rtl/serial_sum_deserializer.sv
// Receive end of the bit-serial adder: packs an LSB-first sum stream plus final carry
// into a parallel word on a valid/ready handshake. Optional parity check: DESER_PARITY_EN.
module serial_sum_deserializer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         carry_in,
    input  logic         out_ready,
    output logic [N-1:0] sum_out,
    output logic         cout_out,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun
`ifdef DESER_PARITY_EN
    ,
    input  logic         parity_in,
    output logic         parity_err
`endif
);

    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       shreg_reg, shreg_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N-1:0]       sum_reg, sum_next;
    logic               cout_reg, cout_next;
    logic               valid_reg, valid_next;
    logic               overrun_reg, overrun_next;
    logic [N-1:0]       shift_word;
`ifdef DESER_PARITY_EN
    logic               perr_reg, perr_next;
`endif

    // New bits enter at the MSB so that after N shifts the first (LSB) bit sits at bit 0.
    assign shift_word = {bit_in, shreg_reg[N-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            cnt_reg     <= '0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            cnt_reg     <= cnt_next;
            sum_reg     <= sum_next;
            cout_reg    <= cout_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
`ifdef DESER_PARITY_EN
            perr_reg    <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        cnt_next     = cnt_reg;
        sum_next     = sum_reg;
        cout_next    = cout_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
`ifdef DESER_PARITY_EN
        perr_next    = perr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    shreg_next = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // A start here restarts the frame and wins over a same-cycle bit.
                if (start) begin
                    shreg_next = '0;
                    cnt_next   = '0;
                end else if (bit_valid) begin
                    shreg_next = shift_word;
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(N - 1)) begin
                        sum_next   = shift_word;
                        cout_next  = carry_in;
                        valid_next = 1'b1;
`ifdef DESER_PARITY_EN
                        perr_next  = (^{shift_word, carry_in}) ^ parity_in;
`endif
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_next = 1'b0;
`ifdef DESER_PARITY_EN
                    perr_next  = 1'b0;
`endif
                    if (start) begin
                        shreg_next = '0;
                        cnt_next   = '0;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (start) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sum_out   = sum_reg;
    assign cout_out  = cout_reg;
    assign out_valid = valid_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg == SHIFT);
`ifdef DESER_PARITY_EN
    assign parity_err = perr_reg;
`endif

endmodule
